operand_sequencer: RTL and testbench

Top-level controller that drives the serial byte-entry unit and the arithmetic datapath. It enables byte entry and collects two 8-bit operands and one opcode byte. It then launches the datapath with a one-cycle start pulse, waits for completion under a timeout, and holds the 16-bit result for display until the user starts again or aborts. It sits between the button front-end, the byte-entry unit and the ALU.

---
 rtl/operand_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_operand_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Operand sequencer: collects two operand bytes and an opcode from the byte-entry
// unit, launches the ALU, waits for completion with a timeout and holds the result.
module operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_abort,
    input  logic [7:0]  in_value,
    input  logic        in_ready,
    output logic        in_enable,
    output logic [7:0]  operand_a,
    output logic [7:0]  operand_b,
    output logic [1:0]  op_sel,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic [1:0]  err_code,
    output logic [2:0]  state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_GET_OP = 3'd3,
        S_EXEC   = 3'd4,
        S_WAIT   = 3'd5,
        S_SHOW   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              start_dly_q, start_dly_d;
    logic              abort_dly_q, abort_dly_d;
    logic              start_edge_q, start_edge_d;
    logic              abort_edge_q, abort_edge_d;
    logic              in_enable_q, in_enable_d;
    logic              alu_start_q, alu_start_d;
    logic [7:0]        operand_a_q, operand_a_d;
    logic [7:0]        operand_b_q, operand_b_d;
    logic [1:0]        op_sel_q, op_sel_d;
    logic [15:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        start_dly_d    = btn_start;
        abort_dly_d    = btn_abort;
        start_edge_d   = btn_start & ~start_dly_q;
        abort_edge_d   = btn_abort & ~abort_dly_q;
        state_d        = state_q;
        operand_a_d    = operand_a_q;
        operand_b_d    = operand_b_q;
        op_sel_d       = op_sel_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_code_d     = err_code_q;
        cnt_d          = cnt_q;

        if (abort_edge_q && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            result_valid_d = 1'b0;
            err_code_d     = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    result_valid_d = 1'b0;
                    err_code_d     = 2'b00;
                    if (start_edge_q) state_d = S_GET_A;
                end
                S_GET_A: begin
                    if (in_ready) begin
                        operand_a_d = in_value;
                        state_d     = S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (in_ready) begin
                        operand_b_d = in_value;
                        state_d     = S_GET_OP;
                    end
                end
                S_GET_OP: begin
                    if (in_ready) begin
                        if (|in_value[7:2]) begin
                            err_code_d = 2'b01;
                            state_d    = S_ERR;
                        end else begin
                            op_sel_d = in_value[1:0];
                            state_d  = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final allowed cycle still wins over the timeout.
                    if (alu_done) begin
                        result_d       = alu_result;
                        result_valid_d = 1'b1;
                        state_d        = S_SHOW;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        if (cnt_q >= CNT_LAST) begin
                            err_code_d = 2'b10;
                            state_d    = S_ERR;
                        end
                    end
                end
                S_SHOW: begin
                    if (start_edge_q) begin
                        result_valid_d = 1'b0;
                        state_d        = S_GET_A;
                    end
                end
                S_ERR: begin
                    if (start_edge_q) begin
                        err_code_d = 2'b00;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        in_enable_d = (state_d == S_GET_A) || (state_d == S_GET_B) || (state_d == S_GET_OP);
        alu_start_d = (state_d == S_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            // Delay registers come out of reset as "pressed" so a button held
            // through reset needs a release before it can register an edge.
            start_dly_q    <= 1'b1;
            abort_dly_q    <= 1'b1;
            start_edge_q   <= 1'b0;
            abort_edge_q   <= 1'b0;
            in_enable_q    <= 1'b0;
            alu_start_q    <= 1'b0;
            operand_a_q    <= 8'h00;
            operand_b_q    <= 8'h00;
            op_sel_q       <= 2'b00;
            result_q       <= 16'h0000;
            result_valid_q <= 1'b0;
            err_code_q     <= 2'b00;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            start_dly_q    <= start_dly_d;
            abort_dly_q    <= abort_dly_d;
            start_edge_q   <= start_edge_d;
            abort_edge_q   <= abort_edge_d;
            in_enable_q    <= in_enable_d;
            alu_start_q    <= alu_start_d;
            operand_a_q    <= operand_a_d;
            operand_b_q    <= operand_b_d;
            op_sel_q       <= op_sel_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_code_q     <= err_code_d;
            cnt_q          <= cnt_d;
        end
    end

    assign state        = state_q;
    assign in_enable    = in_enable_q;
    assign alu_start    = alu_start_q;
    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign op_sel       = op_sel_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_operand_sequencer;

    localparam int T = 4;
    localparam int M_IDLE = 0, M_GETA = 1, M_GETB = 2, M_GETOP = 3,
                   M_EXEC = 4, M_WAIT = 5, M_SHOW = 6, M_ERR = 7;

    logic        clk, rst, btn_start, btn_abort, in_ready, in_enable;
    logic [7:0]  in_value, operand_a, operand_b;
    logic [1:0]  op_sel, err_code;
    logic        alu_start, alu_done, result_valid;
    logic [15:0] alu_result, result;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    int starts_seen = 0;
    int alu_delay = 0;
    bit rand_mode = 0;
    bit live = 0;

    // behavioural model state
    int          m_state;
    logic [7:0]  m_a, m_b;
    logic [1:0]  m_op, m_err;
    logic [15:0] m_res;
    logic        m_rv;
    bit          s_prev, a_prev, s_edge, a_edge;
    longint      cyc = 0;
    longint      deadline = 0;

    operand_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_abort(btn_abort),
        .in_value(in_value), .in_ready(in_ready), .in_enable(in_enable),
        .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .result(result), .result_valid(result_valid), .err_code(err_code),
        .state(state)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0: alu_fn = {8'h00, a} + {8'h00, b};
            2'd1: alu_fn = {8'h00, a} - {8'h00, b};
            2'd2: alu_fn = {8'h00, a & b};
            default: alu_fn = {8'h00, a} * {8'h00, b};
        endcase
    endfunction

    // Model: evaluated on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_state = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_err = 0; m_res = 0; m_rv = 0;
            s_prev = 1; a_prev = 1; s_edge = 0; a_edge = 0;
            live = 1;
        end else begin
            nxt = m_state;
            if (a_edge && m_state != M_IDLE) begin
                nxt = M_IDLE; m_err = 0; m_rv = 0;
            end else begin
                case (m_state)
                    M_IDLE:  begin m_err = 0; m_rv = 0; if (s_edge) nxt = M_GETA; end
                    M_GETA:  if (in_ready) begin m_a = in_value; nxt = M_GETB; end
                    M_GETB:  if (in_ready) begin m_b = in_value; nxt = M_GETOP; end
                    M_GETOP: if (in_ready) begin
                                 if (in_value <= 8'd3) begin m_op = in_value[1:0]; nxt = M_EXEC; end
                                 else begin m_err = 2'b01; nxt = M_ERR; end
                             end
                    M_EXEC:  begin deadline = cyc + T; nxt = M_WAIT; end
                    M_WAIT:  if (alu_done) begin m_res = alu_result; m_rv = 1; nxt = M_SHOW; end
                             else if (cyc == deadline) begin m_err = 2'b10; nxt = M_ERR; end
                    M_SHOW:  if (s_edge) begin m_rv = 0; nxt = M_GETA; end
                    default: if (s_edge) begin m_err = 0; nxt = M_IDLE; end
                endcase
            end
            m_state = nxt;
            s_edge = btn_start && !s_prev; s_prev = btn_start;
            a_edge = btn_abort && !a_prev; a_prev = btn_abort;
        end
        cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (alu_start === 1'b1) starts_seen++;
        if (live) begin
            chk("state", {29'b0, state}, m_state[31:0]);
            chk("in_enable", {31'b0, in_enable}, {31'b0, (m_state >= M_GETA && m_state <= M_GETOP)});
            chk("alu_start", {31'b0, alu_start}, {31'b0, (m_state == M_EXEC)});
            chk("operand_a", {24'b0, operand_a}, {24'b0, m_a});
            chk("operand_b", {24'b0, operand_b}, {24'b0, m_b});
            chk("op_sel", {30'b0, op_sel}, {30'b0, m_op});
            chk("result", {16'b0, result}, {16'b0, m_res});
            chk("result_valid", {31'b0, result_valid}, {31'b0, m_rv});
            chk("err_code", {30'b0, err_code}, {30'b0, m_err});
        end
    end

    // ALU responder: done pulse alu_delay cycles after alu_start (0 = never).
    initial begin
        int pend;
        pend = 0;
        alu_done = 0;
        alu_result = 0;
        forever begin
            @(negedge clk);
            alu_done = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    alu_done = 1;
                    alu_result = rand_mode ? 16'($urandom) : alu_fn(m_a, m_b, m_op);
                end
            end
            if (rand_mode && pend == 0 && $urandom_range(0, 19) == 0) begin
                alu_done = 1;
                alu_result = 16'($urandom);
            end
            if (alu_start === 1'b1) pend = rand_mode ? int'($urandom_range(0, 6)) : alu_delay;
        end
    end

    task automatic press_start();
        @(negedge clk); btn_start = 1;
        @(negedge clk); btn_start = 0;
    endtask

    task automatic press_abort();
        @(negedge clk); btn_abort = 1;
        @(negedge clk); btn_abort = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk); in_value = v; in_ready = 1;
        @(negedge clk); in_ready = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_three(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        press_start();
        @(negedge clk);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    initial begin
        int s0;
        rst = 1; btn_start = 0; btn_abort = 0; in_ready = 0; in_value = 0;
        wait_cycles(3);
        rst = 0;
        chk("reset_state", {29'b0, state}, 0);
        chk("reset_in_enable", {31'b0, in_enable}, 0);
        chk("reset_result", {16'b0, result}, 0);
        chk("reset_err", {30'b0, err_code}, 0);

        // nominal add
        alu_delay = 3;
        press_start();
        @(negedge clk);
        chk("start_latency_state", {29'b0, state}, 1);
        chk("start_latency_en", {31'b0, in_enable}, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        chk("exec_pulse", {31'b0, alu_start}, 1);
        wait_cycles(4);
        chk("add_state", {29'b0, state}, 6);
        chk("add_a", {24'b0, operand_a}, 32'h12);
        chk("add_b", {24'b0, operand_b}, 32'h34);
        chk("add_op", {30'b0, op_sel}, 0);
        chk("add_result", {16'b0, result}, 32'h46);
        chk("add_rv", {31'b0, result_valid}, 1);
        chk("add_one_start", starts_seen, 1);
        chk("model_add_result", {16'b0, m_res}, 32'h46);

        // rerun from SHOW
        press_start();
        @(negedge clk);
        chk("rerun_state", {29'b0, state}, 1);
        chk("rerun_rv", {31'b0, result_valid}, 0);
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h03);
        wait_cycles(4);
        chk("mul_result", {16'b0, result}, 32'h000F);
        chk("mul_state", {29'b0, state}, 6);

        press_abort();
        @(negedge clk);
        chk("abort_show_state", {29'b0, state}, 0);

        // bad opcode
        s0 = starts_seen;
        enter_three(8'h01, 8'h02, 8'h07);
        chk("badop_state", {29'b0, state}, 7);
        chk("badop_err", {30'b0, err_code}, 1);
        wait_cycles(2);
        chk("badop_no_start", starts_seen, s0);
        press_start();
        @(negedge clk);
        chk("err_exit_state", {29'b0, state}, 0);
        chk("err_exit_err", {30'b0, err_code}, 0);

        // timeout, no done
        alu_delay = 0;
        enter_three(8'h01, 8'h02, 8'h00);
        wait_cycles(4);
        chk("timeout_still_wait", {29'b0, state}, 5);
        wait_cycles(1);
        chk("timeout_state", {29'b0, state}, 7);
        chk("timeout_err", {30'b0, err_code}, 2);
        press_start();
        @(negedge clk);

        // done on the limit cycle
        alu_delay = T;
        enter_three(8'h01, 8'h02, 8'h00);
        wait_cycles(4);
        chk("limit_wait", {29'b0, state}, 5);
        wait_cycles(1);
        chk("limit_show", {29'b0, state}, 6);
        chk("limit_result", {16'b0, result}, 3);

        // abort in GET_B
        press_start();
        @(negedge clk);
        send_byte(8'hAA);
        press_abort();
        @(negedge clk);
        chk("abort_state", {29'b0, state}, 0);
        chk("abort_en", {31'b0, in_enable}, 0);
        chk("abort_a", {24'b0, operand_a}, 32'hAA);
        send_byte(8'h55);
        chk("abort_ignore_state", {29'b0, state}, 0);
        chk("abort_ignore_b", {24'b0, operand_b}, 2);

        // reset mid-WAIT with start held
        alu_delay = 0;
        enter_three(8'h09, 8'h09, 8'h01);
        wait_cycles(2);
        btn_start = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        wait_cycles(4);
        chk("rst_state", {29'b0, state}, 0);
        chk("rst_a", {24'b0, operand_a}, 0);
        chk("rst_result", {16'b0, result}, 0);
        btn_start = 0;
        wait_cycles(2);
        chk("rst_no_edge", {29'b0, state}, 0);
        press_start();
        @(negedge clk);
        chk("rst_repress", {29'b0, state}, 1);

        // randomized traffic
        rand_mode = 1;
        repeat (3000) begin
            @(negedge clk);
            btn_start = ($urandom_range(0, 9) == 0);
            btn_abort = ($urandom_range(0, 39) == 0);
            in_ready  = ($urandom_range(0, 2) == 0);
            in_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 0; btn_start = 0; btn_abort = 0; in_ready = 0;
        wait_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
